bilinear_interp: RTL

BILINEAR_INTERP -- requirements
Module: bilinear_interp

---
 rtl/bilinear_interp.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bilinear_interp.sv
// Purpose: 2x2 bilinear pixel interpolator with frame position tagging and an output FIFO.
// Latency: 3 pipeline stages into the FIFO; first mtvalid 4 cycles after the input transfer.
// Backpressure: ptready is credit-based (FIFO count + in-flight stages < FIFO_DEPTH); pipeline never stalls.
module bilinear_interp #(
   parameter int img_width  = 640,
   parameter int img_height = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] lu,
   input  logic [7:0] ru,
   input  logic [7:0] ld,
   input  logic [7:0] rd,
   input  logic [5:0] yfrac,
   input  logic [5:0] xfrac,
   input  logic       ptvalid,
   input  logic       ptlast,
   output logic       ptready,
   output logic [7:0] mtdata,
   output logic       mtvalid,
   output logic       mtuser,
   output logic       mtlast,
   input  logic       mtready,
   output logic       frame_err
);

   localparam int XW = (img_width > 1) ? $clog2(img_width) : 1;
   localparam int YW = (img_height > 1) ? $clog2(img_height) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [XW-1:0] X_LAST = XW'(img_width - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(img_height - 1);

   // frame position and sticky error
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          frame_err_q, frame_err_d;

   // stage 1: horizontal blend
   logic          s1_vld_q, s1_vld_d;
   logic [13:0]   s1_top_q, s1_top_d;
   logic [13:0]   s1_bot_q, s1_bot_d;
   logic [5:0]    s1_yfrac_q, s1_yfrac_d;
   logic          s1_user_q, s1_user_d;
   logic          s1_last_q, s1_last_d;

   // stage 2: vertical blend
   logic          s2_vld_q, s2_vld_d;
   logic [19:0]   s2_acc_q, s2_acc_d;
   logic          s2_user_q, s2_user_d;
   logic          s2_last_q, s2_last_d;

   // stage 3: rounded result, feeds the FIFO write port
   logic          s3_vld_q, s3_vld_d;
   logic [7:0]    s3_dat_q, s3_dat_d;
   logic          s3_user_q, s3_user_d;
   logic          s3_last_q, s3_last_d;

   // output FIFO, entry = {data, user, last}
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [9:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          in_xfer;
   logic          at_end;
   logic          wr_en;
   logic          rd_en;
   logic [CW:0]   occ;
   logic [6:0]    xw_inv;
   logic [6:0]    yw_inv;
   logic [9:0]    head;

   // credit check from registered state only, then handshake decode
   always_comb begin
      occ     = (CW+1)'(count_q) + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q) + (CW+1)'(s3_vld_q);
      ptready = (occ < (CW+1)'(FIFO_DEPTH));
      in_xfer = ptvalid && ptready;
      at_end  = (x_q == X_LAST) && (y_q == Y_LAST);
   end

   // advance x/y per accepted bundle; ptlast forces the next bundle to (0,0)
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      frame_err_d = frame_err_q;
      if (in_xfer) begin
         if (ptlast != at_end) begin
            frame_err_d = 1'b1;
         end
         if (ptlast) begin
            x_d = '0;
            y_d = '0;
         end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // three-stage arithmetic pipeline; every stage advances every cycle
   always_comb begin
      xw_inv     = 7'd64 - {1'b0, xfrac};
      s1_vld_d   = in_xfer;
      s1_top_d   = {6'd0, lu} * {7'd0, xw_inv} + {6'd0, ru} * {8'd0, xfrac};
      s1_bot_d   = {6'd0, ld} * {7'd0, xw_inv} + {6'd0, rd} * {8'd0, xfrac};
      s1_yfrac_d = yfrac;
      s1_user_d  = (x_q == '0) && (y_q == '0);
      s1_last_d  = (x_q == X_LAST);

      yw_inv     = 7'd64 - {1'b0, s1_yfrac_q};
      s2_vld_d   = s1_vld_q;
      s2_acc_d   = {6'd0, s1_top_q} * {13'd0, yw_inv} + {6'd0, s1_bot_q} * {14'd0, s1_yfrac_q};
      s2_user_d  = s1_user_q;
      s2_last_d  = s1_last_q;

      s3_vld_d   = s2_vld_q;
      s3_dat_d   = 8'((s2_acc_q + 20'd2048) >> 12);
      s3_user_d  = s2_user_q;
      s3_last_d  = s2_last_q;
   end

   // FIFO pointer/count update; outputs read zero while empty
   always_comb begin
      wr_en    = s3_vld_q;
      mtvalid  = (count_q != '0);
      rd_en    = mtvalid && mtready;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = {s3_dat_q, s3_user_q, s3_last_q};
      end
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
      head     = mem_q[rd_ptr_q];
      mtdata   = mtvalid ? head[9:2] : 8'd0;
      mtuser   = mtvalid ? head[1]   : 1'b0;
      mtlast   = mtvalid ? head[0]   : 1'b0;
      frame_err = frame_err_q;
   end

   // control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= '0;
         frame_err_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s3_vld_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         frame_err_q <= frame_err_d;
         s1_vld_q    <= s1_vld_d;
         s2_vld_q    <= s2_vld_d;
         s3_vld_q    <= s3_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // datapath registers carry no reset; their valid bits qualify them
   always_ff @(posedge clk) begin
      s1_top_q   <= s1_top_d;
      s1_bot_q   <= s1_bot_d;
      s1_yfrac_q <= s1_yfrac_d;
      s1_user_q  <= s1_user_d;
      s1_last_q  <= s1_last_d;
      s2_acc_q   <= s2_acc_d;
      s2_user_q  <= s2_user_d;
      s2_last_q  <= s2_last_d;
      s3_dat_q   <= s3_dat_d;
      s3_user_q  <= s3_user_d;
      s3_last_q  <= s3_last_d;
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
